// File: rtl/lsu_busmst_pkg.sv
// Shared definitions for the load/store bus initiator: FSM states, access size
// codes, the CLINT address base and the request legality check.
package lsu_busmst_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_CAP  = 2'd2,
        ST_WR   = 2'd3
    } lsu_state_e;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    // Top address byte of the CLINT window; the initiator itself does not decode it.
    localparam logic [7:0] CLINT_BASE = 8'h02;

    function automatic logic req_bad(input logic [1:0] size, input logic [1:0] ofs);
        return (size == 2'd3) ||
               (size == SZ_H && ofs[0]) ||
               (size == SZ_W && ofs != 2'b00);
    endfunction

endpackage

// File: rtl/lsu_busmst_lane.sv
// Byte/half lane logic: load extraction with sign/zero extension and the
// store merge used by read-modify-write.
module lsu_lane
    import lsu_busmst_pkg::*;
(
    input  logic [31:0] rword,
    input  logic [1:0]  ofs,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] wdata,
    output logic [31:0] ldata,
    output logic [31:0] mdata
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = rword[{ofs, 3'b000} +: 8];
        lane_h = ofs[1] ? rword[31:16] : rword[15:0];

        ldata = rword;
        mdata = rword;
        case (size)
            SZ_B: begin
                ldata = {{24{~uns & lane_b[7]}}, lane_b};
                mdata[{ofs, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_H: begin
                ldata = {{16{~uns & lane_h[15]}}, lane_h};
                mdata[{ofs[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_busmst.sv
// Load/store bus initiator: single-beat lr_sram transactions with alignment
// checking, sub-word load extraction and read-modify-write sub-word stores.
module lsu_busmst
    import lsu_busmst_pkg::*;
(
    input  logic        clk,
    input  logic        cpurst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [4:0]  rsp_rd,
    output logic        rsp_err,
    output logic        lr_sram_cs,
    output logic        lr_sram_we,
    output logic [31:0] lr_sram_addr,
    output logic [31:0] lr_sram_wdata,
    input  logic [31:0] sram_rdat,
    input  logic [31:0] clint_rdat,
    input  logic        clint_cs_ff
);

    lsu_state_e  state, state_nxt;

    logic        q_we;
    logic [1:0]  q_size;
    logic        q_uns;
    logic [1:0]  q_ofs;
    logic [31:0] q_wdata;
    logic [4:0]  q_rd;

    logic        cs_nxt, we_nxt, rsp_valid_nxt, rsp_err_nxt;
    logic [31:0] addr_nxt, wdata_nxt, rsp_rdata_nxt;
    logic [4:0]  rsp_rd_nxt;

    logic [31:0] rword, ldata, mdata;
    logic        accept;

    assign req_ready = (state == ST_IDLE);
    assign accept    = req_valid && req_ready;
    assign rword     = clint_cs_ff ? clint_rdat : sram_rdat;

    lsu_lane u_lane (
        .rword (rword),
        .ofs   (q_ofs),
        .size  (q_size),
        .uns   (q_uns),
        .wdata (q_wdata),
        .ldata (ldata),
        .mdata (mdata)
    );

    always_comb begin
        state_nxt     = state;
        cs_nxt        = 1'b0;
        we_nxt        = 1'b0;
        addr_nxt      = lr_sram_addr;
        wdata_nxt     = lr_sram_wdata;
        rsp_valid_nxt = 1'b0;
        rsp_err_nxt   = 1'b0;
        rsp_rdata_nxt = '0;
        rsp_rd_nxt    = rsp_rd;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (req_bad(req_size, req_addr[1:0])) begin
                        rsp_valid_nxt = 1'b1;
                        rsp_err_nxt   = 1'b1;
                        rsp_rd_nxt    = req_rd;
                    end else begin
                        cs_nxt   = 1'b1;
                        addr_nxt = {req_addr[31:2], 2'b00};
                        if (req_we && req_size == SZ_W) begin
                            we_nxt    = 1'b1;
                            wdata_nxt = req_wdata;
                            state_nxt = ST_WR;
                        end else begin
                            state_nxt = ST_RD;
                        end
                    end
                end
            end
            ST_RD: state_nxt = ST_CAP;
            ST_CAP: begin
                // Only sub-word stores pass through RD/CAP with q_we set.
                if (q_we) begin
                    cs_nxt    = 1'b1;
                    we_nxt    = 1'b1;
                    wdata_nxt = mdata;
                    state_nxt = ST_WR;
                end else begin
                    rsp_valid_nxt = 1'b1;
                    rsp_rdata_nxt = ldata;
                    rsp_rd_nxt    = q_rd;
                    state_nxt     = ST_IDLE;
                end
            end
            ST_WR: begin
                rsp_valid_nxt = 1'b1;
                rsp_rd_nxt    = q_rd;
                state_nxt     = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge cpurst) begin
        if (cpurst) begin
            state         <= ST_IDLE;
            lr_sram_cs    <= 1'b0;
            lr_sram_we    <= 1'b0;
            lr_sram_addr  <= '0;
            lr_sram_wdata <= '0;
            rsp_valid     <= 1'b0;
            rsp_err       <= 1'b0;
            rsp_rdata     <= '0;
            rsp_rd        <= '0;
        end else begin
            state         <= state_nxt;
            lr_sram_cs    <= cs_nxt;
            lr_sram_we    <= we_nxt;
            lr_sram_addr  <= addr_nxt;
            lr_sram_wdata <= wdata_nxt;
            rsp_valid     <= rsp_valid_nxt;
            rsp_err       <= rsp_err_nxt;
            rsp_rdata     <= rsp_rdata_nxt;
            rsp_rd        <= rsp_rd_nxt;
        end
    end

    always_ff @(posedge clk or posedge cpurst) begin
        if (cpurst) begin
            q_we    <= 1'b0;
            q_size  <= SZ_W;
            q_uns   <= 1'b0;
            q_ofs   <= '0;
            q_wdata <= '0;
            q_rd    <= '0;
        end else if (accept) begin
            q_we    <= req_we;
            q_size  <= req_size;
            q_uns   <= req_unsigned;
            q_ofs   <= req_addr[1:0];
            q_wdata <= req_wdata;
            q_rd    <= req_rd;
        end
    end

endmodule

// File: tb/tb_lsu_busmst.sv
// Directed bench for lsu_busmst with a small SRAM/CLINT responder model.
module tb_lsu_busmst;
    import lsu_busmst_pkg::*;

    logic        clk = 1'b0;
    logic        cpurst;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [4:0]  rsp_rd;
    logic        lr_sram_cs, lr_sram_we;
    logic [31:0] lr_sram_addr, lr_sram_wdata;
    logic [31:0] sram_rdat, clint_rdat;
    logic        clint_cs_ff;

    logic        pl_en;
    logic [5:0]  pl_idx;
    logic [31:0] pl_val;
    logic [31:0] mem [0:63];
    logic        is_clint;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    always #5 clk = ~clk;

    lsu_busmst dut (
        .clk           (clk),
        .cpurst        (cpurst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_size      (req_size),
        .req_unsigned  (req_unsigned),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_rd        (req_rd),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_rd        (rsp_rd),
        .rsp_err       (rsp_err),
        .lr_sram_cs    (lr_sram_cs),
        .lr_sram_we    (lr_sram_we),
        .lr_sram_addr  (lr_sram_addr),
        .lr_sram_wdata (lr_sram_wdata),
        .sram_rdat     (sram_rdat),
        .clint_rdat    (clint_rdat),
        .clint_cs_ff   (clint_cs_ff)
    );

    assign is_clint = (lr_sram_addr[31:24] == CLINT_BASE);

    // Responder: registered read data one cycle after cs; CLINT reads all-ones.
    always @(posedge clk) begin
        if (cpurst) begin
            sram_rdat   <= '0;
            clint_rdat  <= '0;
            clint_cs_ff <= 1'b0;
        end else begin
            sram_rdat   <= (lr_sram_cs && !lr_sram_we && !is_clint) ? mem[lr_sram_addr[7:2]] : '0;
            clint_rdat  <= (lr_sram_cs && !lr_sram_we && is_clint) ? 32'hFFFF_FFFF : '0;
            clint_cs_ff <= lr_sram_cs && is_clint;
        end
        if (pl_en)
            mem[pl_idx] <= pl_val;
        else if (!cpurst && lr_sram_cs && lr_sram_we && !is_clint)
            mem[lr_sram_addr[7:2]] <= lr_sram_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int unsigned exp_lat;
        int unsigned exp_cs;
        logic [31:0] exp_wr;
    } vec_t;

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [4:0] rd, input logic [31:0] exp_rdata,
                                input logic exp_err, input int unsigned exp_lat,
                                input int unsigned exp_cs, input logic [31:0] exp_wr);
        vec_t v;
        v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.rd = rd; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        v.exp_lat = exp_lat; v.exp_cs = exp_cs; v.exp_wr = exp_wr;
        return v;
    endfunction

    task automatic preload(input logic [5:0] idx, input logic [31:0] val);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = idx; pl_val = val;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic do_req(input vec_t v);
        int unsigned lat, cs_cnt, we_cnt;
        logic got, seen_cs;
        logic [31:0] got_rdata, got_addr, got_wr;
        logic got_err;
        logic [4:0] got_rd;
        lat = 0; cs_cnt = 0; we_cnt = 0; got = 1'b0; seen_cs = 1'b0;
        got_rdata = '0; got_addr = '0; got_wr = '0; got_err = 1'b0; got_rd = '0;
        @(negedge clk);
        check("ready_before", {31'b0, req_ready}, 32'd1);
        check("rsp_quiet_before", {31'b0, rsp_valid}, 32'd0);
        req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
        req_addr = v.addr; req_wdata = v.wdata; req_rd = v.rd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        while (!got && lat < 12) begin
            @(negedge clk);
            lat++;
            if (lr_sram_cs) begin
                cs_cnt++;
                if (!seen_cs) got_addr = lr_sram_addr;
                seen_cs = 1'b1;
                if (lr_sram_we) begin
                    we_cnt++;
                    got_wr = lr_sram_wdata;
                end
            end
            if (rsp_valid) begin
                got = 1'b1;
                got_rdata = rsp_rdata; got_err = rsp_err; got_rd = rsp_rd;
            end
        end
        check("rsp_seen", {31'b0, got}, 32'd1);
        check("latency", lat, v.exp_lat);
        check("rsp_rdata", got_rdata, v.exp_rdata);
        check("rsp_err", {31'b0, got_err}, {31'b0, v.exp_err});
        check("rsp_rd", {27'b0, got_rd}, {27'b0, v.rd});
        check("cs_cycles", cs_cnt, v.exp_cs);
        check("we_cycles", we_cnt, (v.we && !v.exp_err) ? 32'd1 : 32'd0);
        if (!v.exp_err)
            check("bus_addr", got_addr, {v.addr[31:2], 2'b00});
        if (v.we && !v.exp_err)
            check("bus_wdata", got_wr, v.exp_wr);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[$];
        int unsigned viol;
        logic [31:0] clint_lw;

        cpurst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = SZ_W;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; req_rd = '0;
        pl_en = 1'b0; pl_idx = '0; pl_val = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'b0, req_ready}, 32'd1);
        check("rst_cs", {31'b0, lr_sram_cs}, 32'd0);
        check("rst_we", {31'b0, lr_sram_we}, 32'd0);
        check("rst_addr", lr_sram_addr, 32'd0);
        check("rst_wdata", lr_sram_wdata, 32'd0);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
        cpurst = 1'b0;

        // CLINT load straight after reset, then a CLINT word store
        clint_lw = {CLINT_BASE, 24'h004000};
        do_req(mk(1'b0, SZ_W, 1'b0, clint_lw, 32'h0, 5'd30, 32'hFFFF_FFFF, 1'b0, 3, 1, 32'h0));
        do_req(mk(1'b1, SZ_W, 1'b0, {CLINT_BASE, 24'h0}, 32'h5, 5'd29, 32'h0, 1'b0, 2, 1, 32'h5));

        preload(6'd4, 32'h8765_4321);

        vecs.push_back(mk(1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 5'd1,  32'h8765_4321, 1'b0, 3, 1, 32'h0));
        vecs.push_back(mk(1'b0, SZ_B, 1'b0, 32'h13, 32'h0, 5'd2,  32'hFFFF_FF87, 1'b0, 3, 1, 32'h0));
        vecs.push_back(mk(1'b0, SZ_B, 1'b1, 32'h13, 32'h0, 5'd3,  32'h0000_0087, 1'b0, 3, 1, 32'h0));
        vecs.push_back(mk(1'b0, SZ_H, 1'b0, 32'h12, 32'h0, 5'd4,  32'hFFFF_8765, 1'b0, 3, 1, 32'h0));
        vecs.push_back(mk(1'b0, SZ_H, 1'b1, 32'h10, 32'h0, 5'd5,  32'h0000_4321, 1'b0, 3, 1, 32'h0));
        vecs.push_back(mk(1'b0, SZ_B, 1'b0, 32'h10, 32'h0, 5'd6,  32'h0000_0021, 1'b0, 3, 1, 32'h0));
        vecs.push_back(mk(1'b0, SZ_H, 1'b0, 32'h11, 32'h0, 5'd7,  32'h0,         1'b1, 1, 0, 32'h0));
        vecs.push_back(mk(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 5'd8,  32'h0,         1'b1, 1, 0, 32'h0));
        vecs.push_back(mk(1'b1, SZ_W, 1'b0, 32'h12, 32'h1, 5'd9,  32'h0,         1'b1, 1, 0, 32'h0));
        vecs.push_back(mk(1'b1, SZ_B, 1'b0, 32'h11, 32'hAA, 5'd10, 32'h0,        1'b0, 4, 2, 32'h8765_AA21));
        vecs.push_back(mk(1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 5'd11, 32'h8765_AA21, 1'b0, 3, 1, 32'h0));
        vecs.push_back(mk(1'b1, SZ_H, 1'b0, 32'h12, 32'h1234_BEEF, 5'd12, 32'h0, 1'b0, 4, 2, 32'hBEEF_AA21));
        vecs.push_back(mk(1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 5'd13, 32'hBEEF_AA21, 1'b0, 3, 1, 32'h0));
        vecs.push_back(mk(1'b1, SZ_W, 1'b0, 32'h14, 32'hCAFE_F00D, 5'd14, 32'h0, 1'b0, 2, 1, 32'hCAFE_F00D));
        vecs.push_back(mk(1'b0, SZ_B, 1'b0, 32'h16, 32'h0, 5'd15, 32'hFFFF_FFFE, 1'b0, 3, 1, 32'h0));
        vecs.push_back(mk(1'b0, SZ_H, 1'b1, 32'h16, 32'h0, 5'd16, 32'h0000_CAFE, 1'b0, 3, 1, 32'h0));
        vecs.push_back(mk(1'b0, SZ_B, 1'b1, 32'h15, 32'h0, 5'd17, 32'h0000_00F0, 1'b0, 3, 1, 32'h0));
        vecs.push_back(mk(1'b1, SZ_B, 1'b0, 32'h17, 32'h11, 5'd18, 32'h0,        1'b0, 4, 2, 32'h11FE_F00D));
        vecs.push_back(mk(1'b0, SZ_W, 1'b0, 32'h14, 32'h0, 5'd19, 32'h11FE_F00D, 1'b0, 3, 1, 32'h0));

        foreach (vecs[i]) do_req(vecs[i]);

        // Misaligned LH followed immediately by a LW accepted in cycle 1
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = SZ_H; req_unsigned = 1'b0;
        req_addr = 32'h11; req_rd = 5'd20;
        @(posedge clk);
        #1 req_size = SZ_W; req_addr = 32'h10; req_rd = 5'd21;
        @(negedge clk);
        check("b2b_c1_valid", {31'b0, rsp_valid}, 32'd1);
        check("b2b_c1_err", {31'b0, rsp_err}, 32'd1);
        check("b2b_c1_rdata", rsp_rdata, 32'd0);
        check("b2b_c1_cs", {31'b0, lr_sram_cs}, 32'd0);
        check("b2b_c1_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("b2b_c2_cs", {31'b0, lr_sram_cs}, 32'd1);
        check("b2b_c2_valid", {31'b0, rsp_valid}, 32'd0);
        @(negedge clk);
        check("b2b_c3_valid", {31'b0, rsp_valid}, 32'd0);
        @(negedge clk);
        check("b2b_c4_valid", {31'b0, rsp_valid}, 32'd1);
        check("b2b_c4_rdata", rsp_rdata, 32'hBEEF_AA21);
        check("b2b_c4_err", {31'b0, rsp_err}, 32'd0);
        check("b2b_c4_rd", {27'b0, rsp_rd}, 32'd21);

        // Reset during CAP of a byte store: no write, no response
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = SZ_B; req_addr = 32'h11;
        req_wdata = 32'h55; req_rd = 5'd22;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("rmw_rst_c1_cs", {31'b0, lr_sram_cs}, 32'd1);
        @(negedge clk);
        cpurst = 1'b1;
        #1;
        check("rmw_rst_cs", {31'b0, lr_sram_cs}, 32'd0);
        check("rmw_rst_we", {31'b0, lr_sram_we}, 32'd0);
        @(negedge clk);
        cpurst = 1'b0;
        viol = 0;
        repeat (5) begin
            @(negedge clk);
            if (lr_sram_cs || rsp_valid) viol++;
        end
        check("rmw_rst_quiet", viol, 32'd0);
        check("rmw_rst_ready", {31'b0, req_ready}, 32'd1);
        do_req(mk(1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 5'd23, 32'hBEEF_AA21, 1'b0, 3, 1, 32'h0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
